// File: rtl/uart_mem_pkg.sv
// Shared types and constants for the UART-to-RAM image loader.
// Holds the receiver/loader state encodings and the bit-timing helper.
package uart_mem_pkg;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    DATA
  } ld_state_t;

  // Integer truncation, so the actual baud rate may sit slightly above nominal.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle
// byte_valid / byte_err pulses at the stop-bit sample.
module uart_rx
  import uart_mem_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic          sync1_reg, sync2_reg;
  rx_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          valid_reg, valid_next;
  logic          err_reg, err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      state_reg <= RX_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      sync1_reg <= rx_i;
      sync2_reg <= sync1_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        cnt_next = '0;
        if (!sync2_reg) state_next = RX_START;
      end
      RX_START: begin
        // Re-check at mid start bit; a line already high again was a glitch.
        if (cnt_reg == HALF_CNT) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = sync2_reg ? RX_IDLE : RX_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          shift_next = {sync2_reg, shift_reg[7:1]};
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == 3'd7) state_next = RX_STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          valid_next = sync2_reg;
          err_next   = !sync2_reg;
          state_next = RX_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_reg;
  assign byte_err   = err_reg;
  assign byte_data  = shift_reg;

endmodule

// File: rtl/uart_mem_loader.sv
// Parses header/length/data frames from the UART and drives the block RAM
// write port, writing data bytes to addresses 0..N-1.
module uart_mem_loader
  import uart_mem_pkg::*;
#(
  parameter int         CLK_HZ = 12_000_000,
  parameter int         BAUD   = 115200,
  parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       w_en,
  output logic [7:0] w_addr,
  output logic [7:0] w_data,
  output logic       busy,
  output logic       load_done,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_err;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_err  (byte_err)
  );

  ld_state_t  state_reg, state_next;
  logic [8:0] remaining_reg, remaining_next;
  logic [7:0] addr_reg, addr_next;
  logic       w_en_reg, w_en_next;
  logic [7:0] w_addr_reg, w_addr_next;
  logic [7:0] w_data_reg, w_data_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       ferr_reg, ferr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      addr_reg      <= '0;
      w_en_reg      <= 1'b0;
      w_addr_reg    <= '0;
      w_data_reg    <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      ferr_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      addr_reg      <= addr_next;
      w_en_reg      <= w_en_next;
      w_addr_reg    <= w_addr_next;
      w_data_reg    <= w_data_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      ferr_reg      <= ferr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    addr_next      = addr_reg;
    w_en_next      = 1'b0;
    w_addr_next    = w_addr_reg;
    w_data_next    = w_data_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    ferr_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (byte_err) begin
          ferr_next = 1'b1;
        end else if (byte_valid && byte_data == HEADER) begin
          state_next = LEN;
          busy_next  = 1'b1;
        end
      end
      LEN: begin
        if (byte_err) begin
          ferr_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (byte_valid) begin
          remaining_next = {1'b0, byte_data} + 9'd1;
          addr_next      = '0;
          state_next     = DATA;
        end
      end
      DATA: begin
        // remaining hits 0 on the cycle the last write is on the port, so
        // completion lands exactly one cycle after that w_en.
        if (remaining_reg == 9'd0) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (byte_err) begin
          ferr_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (byte_valid) begin
          w_en_next      = 1'b1;
          w_addr_next    = addr_reg;
          w_data_next    = byte_data;
          addr_next      = addr_reg + 8'd1;
          remaining_next = remaining_reg - 9'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign w_en      = w_en_reg;
  assign w_addr    = w_addr_reg;
  assign w_data    = w_data_reg;
  assign busy      = busy_reg;
  assign load_done = done_reg;
  assign frame_err = ferr_reg;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: a frame-level model queues expected
// writes / completions / errors while a monitor checks what the DUT emits.
module tb_uart_mem_loader;

  localparam int CPB = 10;
  localparam int K_WR = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR = 2;
  localparam logic [7:0] HDR = 8'hA5;

  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       w_en, busy, load_done, frame_err;
  logic [7:0] w_addr, w_data;

  int vectors = 0;
  int miscompares = 0;
  ev_t exp_q[$];

  int m_phase = 0;
  int m_rem = 0;
  int m_addr = 0;
  int cyc = 0;
  int last_wen_cyc = -100;

  uart_mem_loader #(
    .CLK_HZ(1_000_000),
    .BAUD  (100_000),
    .HEADER(8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_i     (rx),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .busy     (busy),
    .load_done(load_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame rules: header opens a frame, next byte is N-1, then N data bytes
  // go to addresses 0.. in order; any stop-bit error aborts and reports.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_q.push_back('{K_ERR, 8'h00, 8'h00});
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (b == HDR) m_phase = 1;
    end else if (m_phase == 1) begin
      m_rem = int'(b) + 1;
      m_addr = 0;
      m_phase = 2;
    end else begin
      exp_q.push_back('{K_WR, 8'(m_addr % 256), b});
      m_addr++;
      m_rem--;
      if (m_rem == 0) begin
        exp_q.push_back('{K_DONE, 8'h00, 8'h00});
        m_phase = 0;
      end
    end
  endtask

  task automatic uart_send(input logic [7:0] b, input bit stop_ok, input int gap_bits);
    model_byte(b, stop_ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB * gap_bits) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check({name, "_drain"}, exp_q.size(), 0);
    check({name, "_busy_after"}, int'(busy), 0);
  endtask

  // Monitor: every DUT output pulse must match the head of the queue.
  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (!rst) begin
      if (w_en) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", w_addr, w_data);
        end else begin
          e = exp_q.pop_front();
          check("write_kind", K_WR, e.kind);
          check("w_addr", int'(w_addr), int'(e.addr));
          check("w_data", int'(w_data), int'(e.data));
          check("busy_during_write", int'(busy), 1);
        end
        last_wen_cyc = cyc;
      end
      if (load_done) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_load_done: got 1, expected 0");
        end else begin
          e = exp_q.pop_front();
          check("done_kind", K_DONE, e.kind);
          check("done_latency", cyc - last_wen_cyc, 1);
          check("busy_at_done", int'(busy), 0);
        end
      end
      if (frame_err) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame_err: got 1, expected 0");
        end else begin
          e = exp_q.pop_front();
          check("err_kind", K_ERR, e.kind);
          check("busy_at_err", int'(busy), 0);
        end
      end
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget, expected completion");
    $fatal(1);
  end

  initial begin
    int len;
    int nglb;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    check("reset_w_en", int'(w_en), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(load_done), 0);
    check("reset_ferr", int'(frame_err), 0);
    check("reset_addr_data", int'({w_addr, w_data}), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic frame
    uart_send(8'hA5, 1, 1);
    check("busy_after_header", int'(busy), 1);
    uart_send(8'h02, 1, 1);
    uart_send(8'h11, 1, 1);
    uart_send(8'h22, 1, 1);
    uart_send(8'h33, 1, 1);
    drain("basic");

    // Maximum length with address wrap
    uart_send(8'hA5, 1, 1);
    uart_send(8'hFF, 1, 1);
    for (int i = 0; i < 256; i++) uart_send(8'(i), 1, 1);
    drain("maxlen");

    // Leading garbage
    uart_send(8'h3C, 1, 1);
    uart_send(8'h00, 1, 1);
    uart_send(8'hA5, 1, 1);
    uart_send(8'h00, 1, 1);
    uart_send(8'h7E, 1, 1);
    drain("garbage");

    // Stop-bit error mid frame, then recovery
    uart_send(8'hA5, 1, 1);
    uart_send(8'h03, 1, 1);
    uart_send(8'h44, 1, 1);
    uart_send(8'h55, 0, 2);
    drain("stoperr");
    uart_send(8'hA5, 1, 1);
    uart_send(8'h00, 1, 1);
    uart_send(8'h99, 1, 1);
    drain("recover");

    // Start-bit glitch while idle
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    drain("glitch");

    // Reset mid frame
    uart_send(8'hA5, 1, 1);
    uart_send(8'h04, 1, 1);
    uart_send(8'h01, 1, 1);
    check("busy_before_reset", int'(busy), 1);
    check("midreset_pending", exp_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_phase = 0;
    check("midreset_w_en", int'(w_en), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_done_ferr", int'({load_done, frame_err}), 0);
    check("midreset_addr_data", int'({w_addr, w_data}), 0);
    uart_send(8'h02, 1, 1);
    uart_send(8'h03, 1, 1);
    uart_send(8'h04, 1, 1);
    uart_send(8'hA5, 1, 1);
    uart_send(8'h01, 1, 1);
    uart_send(8'hC3, 1, 1);
    uart_send(8'hA5, 1, 1);
    drain("after_reset");

    // Randomized frames with garbage, random gaps and occasional stop errors
    for (int f = 0; f < 14; f++) begin
      nglb = $urandom_range(0, 2);
      for (int g = 0; g < nglb; g++) begin
        b = 8'($urandom_range(0, 255));
        if (b == HDR) b = 8'h5A;
        uart_send(b, ($urandom_range(0, 5) != 0), $urandom_range(1, 2));
      end
      len = $urandom_range(0, 11);
      uart_send(HDR, 1, $urandom_range(1, 2));
      uart_send(8'(len), 1, $urandom_range(1, 2));
      for (int i = 0; i <= len; i++) begin
        b = 8'($urandom_range(0, 255));
        uart_send(b, ($urandom_range(0, 15) != 0), $urandom_range(1, 2));
        if (m_phase == 0) break;
      end
      drain("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_mem_loader.md
# uart_mem_loader

Receives an image over the board's UART RX line and writes it into the 256×8 inferred block RAM through that RAM's write port (w_en / w_addr / w_data). It is the upstream stage of the LED pattern player, which keeps reading the same RAM. Frames are a 0xA5 header, a length byte and N data bytes, written to addresses 0..N-1. The player's read side is untouched.

## Interface
Parameters:
- CLK_HZ, 12_000_000, system clock frequency.
- BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer truncation; 104 at the defaults.
- HEADER, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_i  in  1  asynchronous UART RX line; idles high; 8N1, LSB first.
- w_en  out  1  RAM write strobe; one-cycle pulse per data byte.
- w_addr  out  8  RAM write address; valid while w_en=1.
- w_data  out  8  RAM write data; valid while w_en=1.
- busy  out  1  high from the cycle after the header is accepted until the load completes or aborts.
- load_done  out  1  one-cycle pulse after the final write of a frame.
- frame_err  out  1  one-cycle pulse on a UART stop-bit error.

## Operation
UART receiver (sub-module):
- rx_i passes through a 2-FF synchronizer. Both flops reset to 1.
- RX_IDLE: wait for a synchronized 0.
- RX_START: at count CLKS_PER_BIT/2, re-sample the line.
  - If it is 1, treat it as a glitch and return to RX_IDLE.
  - Otherwise go to RX_DATA.
- RX_DATA: sample every CLKS_PER_BIT cycles; shift the 8 bits in LSB first.
- RX_STOP: sample once more, CLKS_PER_BIT cycles after the last data sample.
  - 1: pulse byte_valid with the byte.
  - 0: pulse byte_err; the byte is dropped.
- Both paths return to RX_IDLE.

Loader FSM (states IDLE, LEN, DATA):
- IDLE
  - byte == HEADER: go to LEN, set busy.
  - Any other byte: ignored.
  - byte_err: pulses frame_err only; state unchanged.
- LEN
  - Next byte L. Load remaining = L + 1 (9-bit, range 1..256) and addr = 0.
  - Go to DATA.
- DATA
  - Each byte: w_data = byte, w_addr = addr, w_en = 1 for one cycle.
  - Then addr increments (8-bit, wraps 255 to 0) and remaining decrements.
  - remaining reaches 0: pulse load_done, clear busy, go to IDLE.
- Errors
  - byte_err in LEN or DATA: pulse frame_err, clear busy, go to IDLE.
  - Bytes already written stay in RAM; no rollback.
- A header byte value inside LEN or DATA is ordinary data, not a restart.

Reset:
- All outputs are 0 after reset.
- Both FSMs go to IDLE; counters clear.
- Reset mid-frame discards the frame silently: no load_done, no frame_err.

## Timing
- byte_valid / byte_err: cycle T, at the stop-bit sample.
- w_en: registered, asserted at T+1.
- load_done: T+2 relative to the last data byte, i.e. one cycle after its w_en.
- frame_err: T+1.
- busy: rises at T+1 of the header byte; falls in the same cycle load_done or frame_err pulses.
- Byte rate: at most one byte per 10·CLKS_PER_BIT cycles, so the loader has no backpressure and no buffering.
- The RAM reader runs concurrently. A same-address read/write collision returns old or new data; the player tolerates either.

## Structure
- Package uart_mem_pkg holds:
  - the default HEADER constant;
  - rx_state_t (RX_IDLE, RX_START, RX_DATA, RX_STOP);
  - ld_state_t (IDLE, LEN, DATA);
  - a clks_per_bit(clk_hz, baud) function.
- Sub-module uart_rx:
  - inputs: clk, rst, rx_i;
  - outputs: byte_valid, byte_data[7:0], byte_err;
  - contains the synchronizer and bit-timing counter.
- uart_mem_loader instantiates uart_rx and contains only the loader FSM and the address/count registers.

## Test plan
Bench parameters: CLK_HZ=1_000_000, BAUD=100_000, giving 10 clocks per bit.
- Basic frame: send A5, 02, 11, 22, 33 -> writes (0,11), (1,22), (2,33), each w_en exactly 1 cycle; load_done one cycle after the last w_en; busy low after.
- Max length and wrap: send A5, FF, then 256 bytes 00..FF -> 256 writes, addr i = data i, load_done once; addr register has wrapped to 0.
- Leading garbage: send 3C, 00, A5, 00, 7E -> the first two bytes cause no writes; a single write (0,7E) follows, then load_done.
- Stop-bit error: send A5, 03, 44, then a byte with stop bit 0 -> one write (0,44), then frame_err and busy falls; no load_done. A following A5, 00, 99 loads normally.
- Start glitch: rx_i low for 3 clocks while idle -> no byte_valid, no outputs change.
- Reset mid-frame: assert rst for 1 cycle after A5, 04, 01 -> all outputs 0. The remaining bytes are ignored until a new header arrives; no load_done, no frame_err.
